// File: rtl/aud_sample_feeder.sv
// aud_sample_feeder: sample FIFO between the core and the audio PWM stage.
// The core writes PCM samples over a valid/ready port. The PWM stage receives
// one sample per transfer over a first-word fall-through valid/ready port.
// Playback first primes the FIFO to PRIME_LEVEL entries. Underruns substitute
// a mid-scale sample. Flush clears the buffer. low_water_o is a refill hint.
//
// Optional feature macro: AUD_FEEDER_HOLD_LAST_EN. When it is defined, an
// underrun repeats the last sample that left the FIFO instead of mid-scale.
//
// Ports:
//   clk_i, resetn_i        clock, asynchronous active-low reset
//   enable_i               playback enable (level)
//   flush_i                synchronous FIFO clear (level)
//   wr_valid_i/wr_data_i   upstream sample in; wr_ready_o is the FIFO accept
//   smp_valid_o/smp_data_o sample offered to the PWM stage; smp_ready_i accepts
//   level_o                current occupancy
//   low_water_o            level_o <= LOW_WM
//   underrun_o             one-cycle pulse on an underrun transfer
//   busy_o                 state is not idle
module aud_sample_feeder #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PRIME_LEVEL = 8,
  parameter int unsigned LOW_WM      = 4
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  logic                       enable_i,
  input  logic                       flush_i,
  input  logic                       wr_valid_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  output logic                       wr_ready_o,
  output logic                       smp_valid_o,
  output logic [DATA_WIDTH-1:0]      smp_data_o,
  input  logic                       smp_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       low_water_o,
  output logic                       underrun_o,
  output logic                       busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DepthLv = LW'(DEPTH);
  localparam logic [LW-1:0] PrimeLv = LW'(PRIME_LEVEL);
  localparam logic [LW-1:0] LowLv   = LW'(LOW_WM);
  localparam logic [DATA_WIDTH-1:0] Mid = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] ur_data;
  logic                  empty, push, pop, xfer;

  assign head       = mem_q[rd_ptr_q];
  assign empty      = (level_q == '0);
  // No path from smp_ready_i: a full FIFO stays not-ready even while popping.
  assign wr_ready_o = (level_q < DepthLv) && !flush_i;
  assign push       = wr_valid_i && wr_ready_o;
  assign xfer       = smp_valid_o && smp_ready_i;
  // A transfer during flush still completes, but the entry is not popped.
  assign pop        = xfer && !empty && !flush_i;

  assign level_o     = level_q;
  assign low_water_o = (level_q <= LowLv);
  assign underrun_o  = xfer && empty;

`ifdef AUD_FEEDER_HOLD_LAST_EN
  logic [DATA_WIDTH-1:0] hold_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      hold_q <= Mid;
    end else if (flush_i) begin
      hold_q <= Mid;
    end else if (pop) begin
      hold_q <= head;
    end
  end

  assign ur_data = hold_q;
`else
  assign ur_data = Mid;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (!flush_i) state_d = StPrime;
        StPrime: if (!flush_i && (level_q >= PrimeLv)) state_d = StRun;
        StRun:   if (flush_i) state_d = StPrime;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    smp_valid_o = 1'b0;
    smp_data_o  = Mid;
    busy_o      = (state_q != StIdle);
    case (state_q)
      StRun: begin
        smp_valid_o = 1'b1;
        smp_data_o  = empty ? ur_data : head;
      end
      default: ;
    endcase
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage needs no reset: nothing is read unless level_q counts it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_aud_sample_feeder.sv
// Directed bench for aud_sample_feeder at default parameters.
module tb_aud_sample_feeder;

  localparam logic [7:0] MID = 8'h80;
`ifdef AUD_FEEDER_HOLD_LAST_EN
  localparam logic [7:0] UR_AFTER_17 = 8'h17;
  localparam logic [7:0] UR_AFTER_A5 = 8'hA5;
`else
  localparam logic [7:0] UR_AFTER_17 = 8'h80;
  localparam logic [7:0] UR_AFTER_A5 = 8'h80;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       smp_ready = 1'b0;
  logic       wr_ready, smp_valid, low_water, underrun, busy;
  logic [7:0] smp_data;
  logic [4:0] level;

  int errors = 0;
  int checks = 0;
  int acc;

  aud_sample_feeder dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .enable_i    (enable),
    .flush_i     (flush),
    .wr_valid_i  (wr_valid),
    .wr_data_i   (wr_data),
    .wr_ready_o  (wr_ready),
    .smp_valid_o (smp_valid),
    .smp_data_o  (smp_data),
    .smp_ready_i (smp_ready),
    .level_o     (level),
    .low_water_o (low_water),
    .underrun_o  (underrun),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, fl, wv;
    logic [7:0] wd;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] lvl;
    logic       lw, ur, wrr, bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic fl, input logic wv,
                              input logic [7:0] wd, input logic rdy, input logic ev,
                              input logic [7:0] ed, input logic [4:0] lvl, input logic lw,
                              input logic ur, input logic wrr, input logic bsy);
    vec_t v;
    v.en = en; v.fl = fl; v.wv = wv; v.wd = wd; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.lvl = lvl; v.lw = lw; v.ur = ur; v.wrr = wrr; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge; caller then samples at the falling edge.
  task automatic drive(input logic en, input logic fl, input logic wv, input logic [7:0] wd,
                       input logic rdy);
    @(posedge clk);
    #1;
    enable = en; flush = fl; wr_valid = wv; wr_data = wd; smp_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    enable = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; smp_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, sampled while reset is still asserted.
    #2;
    chk("rst_smp_valid", 32'(smp_valid), 32'(0));
    chk("rst_smp_data",  32'(smp_data),  32'(MID));
    chk("rst_level",     32'(level),     32'(0));
    chk("rst_low_water", 32'(low_water), 32'(1));
    chk("rst_wr_ready",  32'(wr_ready),  32'(1));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_underrun",  32'(underrun),  32'(0));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Prime, fill, drain, underrun, push-on-empty, disable.
    //              en fl wv wd     rdy ev ed           lvl lw ur wrr bsy
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, MID,         0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, MID,         0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, MID,         0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, MID,         0, 1, 0, 1, 1));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1, 0, 1, 8'h10 + 8'(i), 0, 0, MID, 5'(i), (i <= 4), 0, 1, 1));
    end
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, MID,         8, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'h10,       8, 0, 0, 1, 1));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h10 + 8'(k), 5'(8 - k), (k >= 4), 0, 1, 1));
    end
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 1, UR_AFTER_17, 0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, UR_AFTER_17, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 8'hA5, 1, 1, UR_AFTER_17, 0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'hA5,       1, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'hA5,       1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, UR_AFTER_A5, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, MID,         0, 1, 0, 1, 0));

    foreach (vecs[i]) begin
      logic [17:0] act, exp;
      drive(vecs[i].en, vecs[i].fl, vecs[i].wv, vecs[i].wd, vecs[i].rdy);
      act = {smp_valid, smp_data, level, low_water, underrun, wr_ready, busy};
      exp = {vecs[i].ev, vecs[i].ed, vecs[i].lvl, vecs[i].lw, vecs[i].ur, vecs[i].wrr,
             vecs[i].bsy};
      chk($sformatf("vec[%0d] {valid,data,level,lw,ur,wrr,busy}", i), 32'(act), 32'(exp));
    end

    // Back-pressure: 20 offered samples, only 16 fit; none may be lost.
    do_reset();
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1, 0, 1, 8'h40 + 8'(acc), 0);
      chk("bp_wr_ready", 32'(wr_ready), 32'(acc < 16));
      chk("bp_level",    32'(level),    32'(acc));
      if (acc < 16) acc++;
    end
    drive(1, 0, 1, 8'h40 + 8'(acc), 1);
    chk("bp_full_valid",    32'(smp_valid), 32'(1));
    chk("bp_full_data",     32'(smp_data),  32'(8'h40));
    chk("bp_full_wr_ready", 32'(wr_ready),  32'(0));
    chk("bp_full_level",    32'(level),     32'(16));
    drive(1, 0, 1, 8'h40 + 8'(acc), 0);
    chk("bp_pop_wr_ready", 32'(wr_ready), 32'(1));
    chk("bp_pop_level",    32'(level),    32'(15));
    chk("bp_pop_data",     32'(smp_data), 32'(8'h41));
    acc++;
    for (int k = 1; k < 20; k++) begin
      drive(1, 0, (acc < 20), 8'h40 + 8'(acc), 1);
      chk($sformatf("bp_drain_data[%0d]", k), 32'(smp_data), 32'(8'h40 + k));
      if (wr_valid && wr_ready) acc++;
    end
    drive(1, 0, 0, 8'h00, 0);
    chk("bp_drain_level", 32'(level), 32'(0));
    chk("bp_accepted",    32'(acc),   32'(20));

    // Flush in RUN with 10 buffered: data is dropped and the block re-primes.
    do_reset();
    for (int i = 0; i < 10; i++) drive(1, 0, 1, 8'h60 + 8'(i), 0);
    drive(1, 0, 0, 8'h00, 0);
    chk("fl_pre_valid", 32'(smp_valid), 32'(1));
    chk("fl_pre_level", 32'(level),     32'(10));
    drive(1, 1, 1, 8'hEE, 1);
    chk("fl_wr_ready", 32'(wr_ready),  32'(0));
    chk("fl_data",     32'(smp_data),  32'(8'h60));
    chk("fl_underrun", 32'(underrun),  32'(0));
    drive(1, 0, 0, 8'h00, 1);
    chk("fl_post_level", 32'(level),     32'(0));
    chk("fl_post_valid", 32'(smp_valid), 32'(0));
    chk("fl_post_busy",  32'(busy),      32'(1));
    chk("fl_post_data",  32'(smp_data),  32'(MID));
    for (int i = 0; i < 8; i++) drive(1, 0, 1, 8'h70 + 8'(i), 1);
    chk("fl_reprime_valid", 32'(smp_valid), 32'(0));
    drive(1, 0, 0, 8'h00, 1);
    chk("fl_reprime_level", 32'(level), 32'(8));
    drive(1, 0, 0, 8'h00, 0);
    chk("fl_new_valid", 32'(smp_valid), 32'(1));
    chk("fl_new_data",  32'(smp_data),  32'(8'h70));

    // Asynchronous reset between edges with level 5 in RUN.
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 0, 1, 8'h10 + 8'(i), 0);
    drive(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 8'h00, 1);
    drive(1, 0, 0, 8'h00, 1);
    chk("ar_pre_level", 32'(level),    32'(5));
    chk("ar_pre_data",  32'(smp_data), 32'(8'h13));
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_valid",     32'(smp_valid), 32'(0));
    chk("ar_data",      32'(smp_data),  32'(MID));
    chk("ar_level",     32'(level),     32'(0));
    chk("ar_low_water", 32'(low_water), 32'(1));
    chk("ar_underrun",  32'(underrun),  32'(0));
    chk("ar_busy",      32'(busy),      32'(0));
    chk("ar_wr_ready",  32'(wr_ready),  32'(1));
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("ar_rel_busy",  32'(busy),  32'(0));
    chk("ar_rel_level", 32'(level), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
